// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder to a synchronous single-port SRAM, with a one-entry posted-write buffer.
// Latency: zero wait states for reads and writes. A read returns data in its data phase; a write retires to the SRAM in a later cycle that has no read.
// Backpressure: HREADYOUT stays high except in the first cycle of an ERROR response (only when AHB_SRAM_SLAVE_ERR_EN is defined).
//
// Ports:
//   HCLK, HRESETn                         - bus clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA - AHB-Lite address and data phase inputs; HREADY is the bus-wide ready
//   HREADYOUT/HRDATA/HRESP                - responder outputs
//   SRAMCS/SRAMADDR/SRAMWEN/SRAMWDATA     - SRAM request; SRAMWEN is a per-byte write enable, all zero means read
//   SRAMRDATA                             - SRAM read data, valid one cycle after a read request
//
// Optional feature: AHB_SRAM_SLAVE_ERR_EN. When it is defined, misaligned transfers and transfers with
// HSIZE>2 get a two-cycle ERROR response. When it is undefined, low address bits are ignored and
// HSIZE>2 is treated as a word access.
module ahb_sram_slave #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-1:0] SRAMADDR,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS
);

    // Posted write: the address and lanes are known in the address phase,
    // and the data is known in the following data phase.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    lanes;
        logic [31:0]   data;
        logic          pend;
    } wbuf_t;

    wbuf_t         wbuf_q;
    logic          rd_dph_q;
    logic          wr_dph_q;
    logic [AW-1:0] rd_addr_q;

    logic          xfer_acc;
    logic          err_acc;
    logic          rd_acc;
    logic          wr_acc;
    logic          commit;
    logic          rd_hit;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_lanes;

    // Bits above the SRAM window and the SEQ/NONSEQ distinction do not matter here.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign xfer_acc = HSEL & HREADY & HTRANS[1];
    assign req_addr = HADDR[AW+1:2];

    // Select byte lanes from the size and the low address bits. Ignoring the
    // address bits below the access size aligns the access down.
    always_comb begin
        req_lanes = 4'hF;
        case (HSIZE)
            3'd0:    req_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    req_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: req_lanes = 4'hF;
        endcase
    end

`ifdef AHB_SRAM_SLAVE_ERR_EN
    typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} err_state_t;

    err_state_t state_q;
    err_state_t state_d;
    logic       misaligned;

    assign misaligned = (HSIZE > 3'd2)
                      || ((HSIZE == 3'd1) && HADDR[0])
                      || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign err_acc    = xfer_acc & misaligned;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_OK: begin
                state_d = err_acc ? ST_ERR1 : ST_OK;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                // HREADY is high here, so a new transfer can start in this cycle.
                state_d = err_acc ? ST_ERR1 : ST_OK;
            end
            default: begin
                state_d = ST_OK;
            end
        endcase
    end
`else
    assign err_acc   = 1'b0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

    assign rd_acc = xfer_acc & ~HWRITE & ~err_acc;
    assign wr_acc = xfer_acc &  HWRITE & ~err_acc;

    // A read takes the SRAM port in its address phase, so the buffered write waits.
    // A new write always retires the previous entry in the same cycle, so one entry is enough.
    // An errored transfer makes no SRAM access, and any retire waits one cycle.
    assign commit = wbuf_q.pend & ~rd_acc & ~err_acc;

    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWEN   = 4'h0;
        SRAMADDR  = wbuf_q.addr;
        SRAMWDATA = wbuf_q.data;
        if (rd_acc) begin
            SRAMCS   = 1'b1;
            SRAMADDR = req_addr;
        end else if (commit) begin
            SRAMCS    = 1'b1;
            SRAMWEN   = wbuf_q.lanes;
            // In the entry's own data phase the data is still on HWDATA.
            SRAMWDATA = wr_dph_q ? HWDATA : wbuf_q.data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_dph_q  <= 1'b0;
            wr_dph_q  <= 1'b0;
            rd_addr_q <= '0;
            wbuf_q    <= '0;
        end else begin
            rd_dph_q <= rd_acc;
            wr_dph_q <= wr_acc;
            if (rd_acc) begin
                rd_addr_q <= req_addr;
            end
            // If the entry already retired in this cycle, pend is clear and
            // the captured data is never used.
            if (wr_dph_q) begin
                wbuf_q.data <= HWDATA;
            end
            if (wr_acc) begin
                wbuf_q.addr  <= req_addr;
                wbuf_q.lanes <= req_lanes;
                wbuf_q.pend  <= 1'b1;
            end else if (commit) begin
                wbuf_q.pend <= 1'b0;
            end
        end
    end

    // Read-after-write merge. The buffer cannot change between a read's address
    // phase and its data phase: no retire happens during a read address phase, and
    // a new write cannot be accepted in the same cycle. Comparing in the data phase
    // is therefore safe.
    assign rd_hit = rd_dph_q & wbuf_q.pend & (wbuf_q.addr == rd_addr_q);

    always_comb begin
        HRDATA = SRAMRDATA;
        for (int i = 0; i < 4; i++) begin
            if (rd_hit && wbuf_q.lanes[i]) begin
                HRDATA[8*i +: 8] = wbuf_q.data[8*i +: 8];
            end
        end
    end

endmodule
